ifq: RTL
========

IFQ -- requirements
Module: ifq

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of fetch-packet entries; it SHALL be a power of two of at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 pipe_flush  input  1  discard all queued packets.
REQ-005 im_pc  input  64  fetch-packet base PC, 8-byte aligned.
REQ-006 im_instr  input  64  bits [31:0] are the low-address word; bits [63:32] are the high-address word.
REQ-007 im_mask  input  2  bit0 marks the low word valid; bit1 marks the high word valid.
REQ-008 im_bp, im_bp_slot, im_bp_track[1:0], im_bt[63:0]  input  1/1/2/64  predicted-taken flag, slot it applies to, predictor tracking state, and branch target.
REQ-009 im_valid  input  1 / im_ready  output  1  upstream handshake; a packet transfers when both are 1.
REQ-010 if_dec0_pc/instr/bp/bp_track/bt/valid  output  64/32/1/2/64/1  lower-address decoder slot.
REQ-011 if_dec1_pc/instr/bp/bp_track/bt/valid  output  64/32/1/2/64/1  higher-address decoder slot.
REQ-012 if_dec_ready  input  1  decoder accepts both slots together when it is 1.

Function
REQ-013 im_ready SHALL equal NOT full, combinationally, with no pass-through when full.
REQ-014 On enqueue, if im_bp=1 and im_bp_slot=0, the stored mask bit1 SHALL be forced to 0.
REQ-015 A packet with an effective mask of 00 SHALL be accepted and dropped, not stored.
REQ-016 Latency SHALL be 1 cycle: a packet accepted at edge N SHALL be visible at the head after edge N.
REQ-017 For a head mask of 11: dec0 SHALL carry the low word with pc=base; dec1 SHALL carry the high word with pc=base+4.
REQ-018 For a head mask of 01: only dec0 SHALL be valid, carrying the low word.
REQ-019 For a head mask of 10: only dec0 SHALL be valid, carrying the high word with pc=base+4.
REQ-020 if_dec1_valid SHALL never be 1 while if_dec0_valid is 0.
REQ-021 bp, bp_track and bt SHALL appear only on the slot holding the word selected by im_bp_slot; the other slot SHALL show bp=0, bp_track=0 and bt=0.
REQ-022 The head SHALL pop when (if_dec0_valid AND if_dec_ready) is 1; the whole packet SHALL leave in one transfer.
REQ-023 When full, a simultaneous pop and push request SHALL perform the pop only, because im_ready=0.
REQ-024 When neither empty nor full, a simultaneous push and pop SHALL leave the count unchanged.
REQ-025 Read and write pointers SHALL be log2(DEPTH)+1 bits wide, with an extra wrap bit.
REQ-026 The queue SHALL be full when the pointers differ only in the wrap bit, and empty when the pointers are equal.
REQ-027 pipe_flush SHALL reset both pointers to 0 at the next edge, taking priority over a push and a pop in the same cycle.
REQ-028 During the pipe_flush cycle, the outputs SHALL still reflect the pre-flush head.

Reset
REQ-029 On rst: pointers SHALL be 0, all storage SHALL be 0, both decoder valids SHALL be 0, all decoder data outputs SHALL be 0, and im_ready SHALL be 1 once rst is deasserted.
REQ-030 rst asserted mid-transfer SHALL take effect immediately without waiting for a clock edge; the in-flight packet SHALL be lost.

Structure
REQ-031 Packet field widths (PC 64, word 32, bp_track 2) and the packed entry width SHALL be defined in the shared defines.vh.
REQ-032 Storage and pointers SHALL be in one sub-module, fifo_1w1r, parameterised by WIDTH and DEPTH; ifq SHALL hold the mask fixup and slot-steering logic.

Verification
REQ-033 Enqueue pc=0x1000, instr=0x00B3_0013_0051_0113, mask=11, with if_dec_ready=1 -> next cycle dec0 pc=0x1000 instr=0x00510113, dec1 pc=0x1004 instr=0x00B30013, both valid, then empty.
REQ-034 Enqueue pc=0x2000, mask=10 -> only dec0 valid, with pc=0x2004 and the high word; dec1_valid=0.
REQ-035 Enqueue mask=11 with bp=1, bp_slot=0, bt=0x3000 -> only dec0 valid, with bp=1 and bt=0x3000.
REQ-036 Hold if_dec_ready=0 and push 5 packets with DEPTH=4 -> im_ready=0 after 4 accepts; then raise ready -> packets drain in order and im_ready=1 the cycle after the first pop.
REQ-037 Fill 3 entries, assert pipe_flush together with im_valid and if_dec_ready -> next cycle both valids=0 and count=0.
REQ-038 Assert rst asynchronously between edges with 2 entries queued -> valids drop to 0 before the next edge, and im_ready=1 after release.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: field widths, the stored
// fetch-packet entry layout and the predicted-taken mask fixup.
package ifq_pkg;

  localparam int unsigned PcW    = 64;
  localparam int unsigned WordW  = 32;
  localparam int unsigned TrackW = 2;

  typedef struct packed {
    logic [PcW-1:0]     pc;
    logic [2*WordW-1:0] instr;
    logic [1:0]         mask;
    logic               bp;
    logic               bp_slot;
    logic [TrackW-1:0]  bp_track;
    logic [PcW-1:0]     bt;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  // A taken branch in the low word makes the high word unreachable.
  function automatic logic [1:0] fix_mask(logic [1:0] mask, logic bp, logic bp_slot);
    return (bp && !bp_slot) ? {1'b0, mask[0]} : mask;
  endfunction

endpackage

// File: rtl/ifq_if.sv
// Fetch-packet upstream handshake plus the two-slot decoder interface of the IFQ.
// The queue itself is the slave; the fetch unit / decoder environment is the master.
interface ifq_if;
  import ifq_pkg::*;

  logic                pipe_flush;
  logic [PcW-1:0]      im_pc;
  logic [2*WordW-1:0]  im_instr;
  logic [1:0]          im_mask;
  logic                im_bp;
  logic                im_bp_slot;
  logic [TrackW-1:0]   im_bp_track;
  logic [PcW-1:0]      im_bt;
  logic                im_valid;
  logic                im_ready;

  logic [PcW-1:0]      if_dec0_pc;
  logic [WordW-1:0]    if_dec0_instr;
  logic                if_dec0_bp;
  logic [TrackW-1:0]   if_dec0_bp_track;
  logic [PcW-1:0]      if_dec0_bt;
  logic                if_dec0_valid;

  logic [PcW-1:0]      if_dec1_pc;
  logic [WordW-1:0]    if_dec1_instr;
  logic                if_dec1_bp;
  logic [TrackW-1:0]   if_dec1_bp_track;
  logic [PcW-1:0]      if_dec1_bt;
  logic                if_dec1_valid;

  logic                if_dec_ready;

  modport slave (
    input  pipe_flush, im_pc, im_instr, im_mask, im_bp, im_bp_slot, im_bp_track, im_bt,
    input  im_valid, if_dec_ready,
    output im_ready,
    output if_dec0_pc, if_dec0_instr, if_dec0_bp, if_dec0_bp_track, if_dec0_bt, if_dec0_valid,
    output if_dec1_pc, if_dec1_instr, if_dec1_bp, if_dec1_bp_track, if_dec1_bt, if_dec1_valid
  );

  modport master (
    output pipe_flush, im_pc, im_instr, im_mask, im_bp, im_bp_slot, im_bp_track, im_bt,
    output im_valid, if_dec_ready,
    input  im_ready,
    input  if_dec0_pc, if_dec0_instr, if_dec0_bp, if_dec0_bp_track, if_dec0_bt, if_dec0_valid,
    input  if_dec1_pc, if_dec1_instr, if_dec1_bp, if_dec1_bp_track, if_dec1_bt, if_dec1_valid
  );

endinterface

// File: rtl/fifo_1w1r.sv
// Single-write single-read FIFO with wrap-bit pointers, flush and async-reset storage.
// Read data is the head entry, presented combinationally.
module fifo_1w1r #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] WrapOnly = {1'b1, {AW{1'b0}}};

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push, pop;

  assign full_o    = (wptr_q ^ rptr_q) == WrapOnly;
  assign empty_o   = wptr_q == rptr_q;
  assign push      = wr_en_i & ~full_o;
  assign pop       = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrOne;
      if (pop)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: buffers 2-word fetch packets and steers the valid words of
// the head packet onto two decoder slots, lower address first.
module ifq
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic  clk,
  input logic  rst,
  ifq_if.slave bus
);

  entry_t     wr_entry;
  logic [EntryW-1:0] head_bits;
  entry_t     head;
  logic [1:0] mask_eff;
  logic       full, empty, push, pop;

  logic       d0_valid, d0_hi, d1_valid;
  logic       d0_pred, d1_pred;

  assign mask_eff = fix_mask(bus.im_mask, bus.im_bp, bus.im_bp_slot);
  assign bus.im_ready = ~full;
  // Packets left with no valid word are accepted but never stored.
  assign push = bus.im_valid & ~full & (|mask_eff);
  assign pop  = d0_valid & bus.if_dec_ready;

  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = bus.im_pc;
    wr_entry.instr    = bus.im_instr;
    wr_entry.mask     = mask_eff;
    wr_entry.bp       = bus.im_bp;
    wr_entry.bp_slot  = bus.im_bp_slot;
    wr_entry.bp_track = bus.im_bp_track;
    wr_entry.bt       = bus.im_bt;
  end

  fifo_1w1r #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (bus.pipe_flush),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (head_bits),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign head = entry_t'(head_bits);

  always_comb begin
    d0_valid = 1'b0;
    d0_hi    = 1'b0;
    d1_valid = 1'b0;
    if (!empty) begin
      case (head.mask)
        2'b11: begin
          d0_valid = 1'b1;
          d1_valid = 1'b1;
        end
        2'b01: d0_valid = 1'b1;
        2'b10: begin
          d0_valid = 1'b1;
          d0_hi    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Prediction info follows the word named by bp_slot; dec1 only ever holds the high word.
  assign d0_pred = d0_valid & (head.bp_slot == d0_hi);
  assign d1_pred = d1_valid & head.bp_slot;

  always_comb begin
    bus.if_dec0_valid    = d0_valid;
    bus.if_dec0_pc       = '0;
    bus.if_dec0_instr    = '0;
    bus.if_dec0_bp       = 1'b0;
    bus.if_dec0_bp_track = '0;
    bus.if_dec0_bt       = '0;
    bus.if_dec1_valid    = d1_valid;
    bus.if_dec1_pc       = '0;
    bus.if_dec1_instr    = '0;
    bus.if_dec1_bp       = 1'b0;
    bus.if_dec1_bp_track = '0;
    bus.if_dec1_bt       = '0;
    if (d0_valid) begin
      bus.if_dec0_pc    = d0_hi ? head.pc + 64'd4 : head.pc;
      bus.if_dec0_instr = d0_hi ? head.instr[2*WordW-1:WordW] : head.instr[WordW-1:0];
    end
    if (d0_pred) begin
      bus.if_dec0_bp       = head.bp;
      bus.if_dec0_bp_track = head.bp_track;
      bus.if_dec0_bt       = head.bt;
    end
    if (d1_valid) begin
      bus.if_dec1_pc    = head.pc + 64'd4;
      bus.if_dec1_instr = head.instr[2*WordW-1:WordW];
    end
    if (d1_pred) begin
      bus.if_dec1_bp       = head.bp;
      bus.if_dec1_bp_track = head.bp_track;
      bus.if_dec1_bt       = head.bt;
    end
  end

endmodule
